// File: rtl/stage3_hart_scheduler.sv
// stage3_hart_scheduler
// Per-cycle fetch hart scheduler for the multi-hart 3-stage pipeline.
// Tracks per-hart blocked state (miss / WFI) and selects the hart that fetches.
// Policies: mode 0 = round-robin interleave every cycle,
//           mode 1 = switch-on-event, optionally bounded by QUANTUM.
//
// Optional feature macro: STAGE3_HART_SCHED_QUANTUM_EN
//   defined     : mode 1 also switches after QUANTUM consecutive fetch cycles
//   not defined : no quantum counter; mode 1 switches only when current hart is not ready
//
// Ports:
//   CLK          in   clock
//   RST          in   synchronous active-high reset
//   hart_en      in   [NUM_HARTS] static enable mask
//   mode         in   0 = interleave, 1 = switch-on-event
//   block_set    in   [NUM_HARTS] pulse: hart becomes blocked (wins over block_clr)
//   block_clr    in   [NUM_HARTS] pulse: hart becomes unblocked
//   fetch_stall  in   fetch cannot accept this cycle
//   sel_hart     out  [HART_W] registered hart granted fetch
//   sel_valid    out  combinational ready_mask[sel_hart]
//   ready_mask   out  [NUM_HARTS] combinational hart_en & ~blocked
//   switch_pulse out  registered, high on the first cycle a new sel_hart is shown
module stage3_hart_scheduler #(
    parameter int unsigned NUM_HARTS = 4,
    parameter int unsigned HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
    parameter int unsigned QUANTUM   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_HARTS-1:0] hart_en,
    input  logic                 mode,
    input  logic [NUM_HARTS-1:0] block_set,
    input  logic [NUM_HARTS-1:0] block_clr,
    input  logic                 fetch_stall,
    output logic [HART_W-1:0]    sel_hart,
    output logic                 sel_valid,
    output logic [NUM_HARTS-1:0] ready_mask,
    output logic                 switch_pulse
);

    // Elaboration-time parameter range checks
    if (NUM_HARTS < 1 || NUM_HARTS > 16) begin : g_bad_num_harts
        $error("stage3_hart_scheduler: NUM_HARTS out of range 1..16");
    end
    if (QUANTUM < 2 || QUANTUM > 256) begin : g_bad_quantum
        $error("stage3_hart_scheduler: QUANTUM out of range 2..256");
    end

    logic [NUM_HARTS-1:0] blocked;
    logic [NUM_HARTS-1:0] blocked_next;
    logic [HART_W-1:0]    pick;
    logic                 pick_found;
    logic [HART_W-1:0]    cand;
    logic [HART_W-1:0]    sel_next;
    logic                 advance;
    logic                 keep;
    logic                 quantum_ok;

    // Set wins over clear; redundant set/clear naturally have no effect
    assign blocked_next = (blocked & ~block_clr) | block_set;
    assign ready_mask   = hart_en & ~blocked;
    assign sel_valid    = ready_mask[sel_hart];
    // Selection only moves when fetch consumes, or when the current hart cannot fetch
    assign advance      = !fetch_stall || !sel_valid;

`ifdef STAGE3_HART_SCHED_QUANTUM_EN
    localparam int unsigned QCOUNT_W = 8;
    localparam logic [QCOUNT_W:0] QLIMIT = (QCOUNT_W + 1)'(QUANTUM - 1);

    logic [QCOUNT_W-1:0] qcount;

    assign quantum_ok = ({1'b0, qcount} < QLIMIT);

    // Consecutive fetch cycles on the current hart; restarts on any hart change
    always_ff @(posedge CLK) begin
        if (RST) begin
            qcount <= '0;
        end else if (sel_next != sel_hart) begin
            qcount <= '0;
        end else if (sel_valid && !fetch_stall && (qcount != {QCOUNT_W{1'b1}})) begin
            qcount <= qcount + QCOUNT_W'(1);
        end
    end
`else
    assign quantum_ok = 1'b1;
`endif

    // Round-robin search from sel_hart+1, with sel_hart itself checked last
    always_comb begin
        pick       = sel_hart;
        pick_found = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_HARTS; k++) begin
            cand = HART_W'((32'(sel_hart) + k) % NUM_HARTS);
            if (!pick_found && ready_mask[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Next selection; with no ready hart the current index is held
    always_comb begin
        sel_next = sel_hart;
        keep     = 1'b0;
        if (mode && sel_valid) begin
            keep = quantum_ok;
        end
        if (advance && !keep && pick_found) begin
            sel_next = pick;
        end
    end

    // State registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            blocked      <= '0;
            sel_hart     <= '0;
            switch_pulse <= 1'b0;
        end else begin
            blocked      <= blocked_next;
            sel_hart     <= sel_next;
            switch_pulse <= (sel_next != sel_hart);
        end
    end

endmodule

// File: tb/tb_stage3_hart_scheduler.sv
// Bench for stage3_hart_scheduler (NUM_HARTS=4, QUANTUM=4): directed vector
// table with per-cycle expected outputs, checked through a scoreboard queue.
module tb_stage3_hart_scheduler;

`ifdef STAGE3_HART_SCHED_QUANTUM_EN
    localparam int Q = 1;
`else
    localparam int Q = 0;
`endif

    logic       CLK;
    logic       RST;
    logic [3:0] hart_en;
    logic       mode;
    logic [3:0] block_set;
    logic [3:0] block_clr;
    logic       fetch_stall;
    logic [1:0] sel_hart;
    logic       sel_valid;
    logic [3:0] ready_mask;
    logic       switch_pulse;

    stage3_hart_scheduler #(
        .NUM_HARTS (4),
        .QUANTUM   (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .hart_en      (hart_en),
        .mode         (mode),
        .block_set    (block_set),
        .block_clr    (block_clr),
        .fetch_stall  (fetch_stall),
        .sel_hart     (sel_hart),
        .sel_valid    (sel_valid),
        .ready_mask   (ready_mask),
        .switch_pulse (switch_pulse)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic       md;
        logic [3:0] bs;
        logic [3:0] bc;
        logic       st;
        logic       chk;
        logic [1:0] es;
        logic       ev;
        logic [3:0] er;
        logic       esp;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] es;
        logic       ev;
        logic [3:0] er;
        logic       esp;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    function automatic void add(input int rst, input int en, input int md, input int bs,
                                input int bc, input int st, input int chk, input int es,
                                input int ev, input int er, input int esp);
        vec_t v;
        v.rst = 1'(rst);  v.en  = 4'(en);  v.md = 1'(md);  v.bs = 4'(bs);
        v.bc  = 4'(bc);   v.st  = 1'(st);  v.chk = 1'(chk);
        v.es  = 2'(es);   v.ev  = 1'(ev);  v.er = 4'(er);  v.esp = 1'(esp);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    endtask

    initial begin
        exp_t e;
        RST = 1'b1; hart_en = 4'hF; mode = 1'b0;
        block_set = 4'h0; block_clr = 4'h0; fetch_stall = 1'b0;

        //   rst en   md bs   bc   st chk sel    val ready esp
        // Mode 0, all enabled: 0,1,2,3,0
        add(1, 'hF, 0, 0,   0,   0, 0,  0,     0,  0,    0);
        add(0, 'hF, 0, 0,   0,   0, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 0, 0,   0,   0, 1,  1,     1, 'hF,   1);
        add(0, 'hF, 0, 0,   0,   0, 1,  2,     1, 'hF,   1);
        add(0, 'hF, 0, 0,   0,   0, 1,  3,     1, 'hF,   1);
        add(0, 'hF, 0, 0,   0,   0, 1,  0,     1, 'hF,   1);
        // Mode 0, hart 2 disabled: 0,1,3,0,1
        add(1, 'hB, 0, 0,   0,   0, 0,  0,     0,  0,    0);
        add(0, 'hB, 0, 0,   0,   0, 1,  0,     1, 'hB,   0);
        add(0, 'hB, 0, 0,   0,   0, 1,  1,     1, 'hB,   1);
        add(0, 'hB, 0, 0,   0,   0, 1,  3,     1, 'hB,   1);
        add(0, 'hB, 0, 0,   0,   0, 1,  0,     1, 'hB,   1);
        add(0, 'hB, 0, 0,   0,   0, 1,  1,     1, 'hB,   1);
        // Mode 1: quantum of 4 when enabled, otherwise hart 0 held
        add(1, 'hF, 1, 0,   0,   0, 0,  0,     0,  0,    0);
        add(0, 'hF, 1, 0,   0,   0, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   0, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   0, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   0, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   0, 1,  Q,     1, 'hF,   Q);
        add(0, 'hF, 1, 0,   0,   0, 1,  Q,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   0, 1,  Q,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   0, 1,  Q,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   0, 1,  2*Q,   1, 'hF,   Q);
        // Block on selected hart 1 in mode 1, later cleared
        add(1, 'hF, 0, 0,   0,   0, 0,  0,     0,  0,    0);
        add(0, 'hF, 0, 0,   0,   0, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 1, 'h2, 0,   0, 1,  1,     1, 'hF,   1);
        add(0, 'hF, 1, 0,   0,   0, 1,  1,     0, 'hD,   0);
        add(0, 'hF, 0, 0,   'h2, 0, 1,  2,     1, 'hD,   1);
        add(0, 'hF, 0, 0,   0,   0, 1,  3,     1, 'hF,   1);
        add(0, 'hF, 0, 0,   0,   0, 1,  0,     1, 'hF,   1);
        add(0, 'hF, 0, 0,   0,   0, 1,  1,     1, 'hF,   1);
        // Set+clear same cycle on hart 2, then all blocked, then hart 3 freed
        add(0, 'hF, 0, 'h4, 'h4, 0, 1,  2,     1, 'hF,   1);
        add(0, 'hF, 0, 'hB, 0,   0, 1,  3,     1, 'hB,   1);
        add(0, 'hF, 0, 0,   0,   0, 1,  0,     0, 'h0,   1);
        add(0, 'hF, 0, 0,   0,   0, 1,  0,     0, 'h0,   0);
        add(0, 'hF, 0, 0,   'h8, 0, 1,  0,     0, 'h0,   0);
        add(0, 'hF, 0, 0,   0,   0, 1,  0,     0, 'h8,   0);
        add(0, 'hF, 0, 0,   0,   0, 1,  3,     1, 'h8,   1);
        add(0, 'hF, 0, 0,   0,   0, 1,  3,     1, 'h8,   0);
        // Stall 3 cycles on hart 0 in mode 1: quantum count must not advance
        add(1, 'hF, 1, 0,   0,   0, 0,  0,     0,  0,    0);
        add(0, 'hF, 1, 0,   0,   1, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   1, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   1, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   0, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   0, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   0, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   0, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 1, 0,   0,   0, 1,  Q,     1, 'hF,   Q);
        // Mode 0 stalled on a valid hart holds the selection
        add(0, 'hF, 0, 0,   0,   1, 1,  Q,     1, 'hF,   0);
        add(0, 'hF, 0, 0,   0,   1, 1,  Q,     1, 'hF,   0);
        add(0, 'hF, 0, 0,   0,   0, 1,  Q,     1, 'hF,   0);
        add(0, 'hF, 0, 'h3, 0,   0, 1,  1+Q,   1, 'hF,   1);
        // Reset mid-run with block_set present clears blocked state
        add(1, 'hF, 0, 'hF, 0,   0, 0,  0,     0,  0,    0);
        add(0, 'hF, 0, 0,   0,   0, 1,  0,     1, 'hF,   0);
        add(0, 'hF, 0, 0,   0,   0, 1,  1,     1, 'hF,   1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            RST         = vecs[i].rst;
            hart_en     = vecs[i].en;
            mode        = vecs[i].md;
            block_set   = vecs[i].bs;
            block_clr   = vecs[i].bc;
            fetch_stall = vecs[i].st;
            if (vecs[i].chk) begin
                e.idx = i;           e.es = vecs[i].es; e.ev = vecs[i].ev;
                e.er  = vecs[i].er;  e.esp = vecs[i].esp;
                sb.push_back(e);
            end
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sel_hart",     e.idx, 4'(sel_hart),     4'(e.es));
                check("sel_valid",    e.idx, 4'(sel_valid),    4'(e.ev));
                check("ready_mask",   e.idx, ready_mask,       e.er);
                check("switch_pulse", e.idx, 4'(switch_pulse), 4'(e.esp));
            end
        end

        @(negedge CLK);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
